// File: rtl/seg7_scan_driver.sv
// Eight-digit hex 7-segment scan driver with a frame-synchronous snapshot.
// Latency: an/seg registered, one cycle behind digit_idx/snap. No backpressure; free-running scan.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (blank leading zero digits above digit 0).
module seg7_scan_driver #(
    parameter int CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] display_data,
    input  logic        freeze,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        frame_tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_div_cnt;
    logic [2:0]    r_digit_idx;
    logic [31:0]   r_snap;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;

    logic          w_tick;
    logic          w_frame;
    logic [3:0]    w_nibble;
    logic [6:0]    w_hex;
    logic          w_blank;
    logic [7:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;

    // Active-low patterns, bit 6 = g ... bit 0 = a.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign w_tick     = (r_div_cnt == DIV_MAX);
    assign w_frame    = w_tick && (r_digit_idx == 3'd7);
    assign frame_tick = w_frame;

    assign w_nibble = r_snap[{r_digit_idx, 2'b00} +: 4];
    assign w_hex    = hex7(w_nibble);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [7:0] w_lead_nz;

    // w_lead_nz[k]: some nibble in k..7 of the snapshot is non-zero.
    always_comb begin
        w_lead_nz = 8'h00;
        for (int k = 0; k < 8; k++) begin
            w_lead_nz[k] = |(r_snap >> (4 * k));
        end
    end

    assign w_blank = (r_digit_idx != 3'd0) && !w_lead_nz[r_digit_idx];
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_an_nxt  = ~(8'b1 << r_digit_idx);
        w_seg_nxt = w_hex;
        if (w_blank) begin
            w_an_nxt  = 8'hFF;
            w_seg_nxt = 7'h7F;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt   <= '0;
            r_digit_idx <= 3'd0;
            r_snap      <= 32'h0;
            r_an        <= 8'hFF;
            r_seg       <= 7'h7F;
        end else begin
            if (w_tick) begin
                r_div_cnt   <= '0;
                r_digit_idx <= r_digit_idx + 3'd1;
            end else begin
                r_div_cnt   <= r_div_cnt + 1'b1;
            end
            // freeze only matters at the frame boundary, so a frame never tears.
            if (w_frame && !freeze) begin
                r_snap <= display_data;
            end
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule
